// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter with parallel load, synchronous clear, registered
// Gray output, sticky range error and cascadeable terminal count.
module mod_updown_counter #(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MOD       = 16,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] ZERO      = WIDTH'(64'd0);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(64'd1);
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MOD - 64'd1);
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] bin);
        return bin ^ (bin >> 1'b1);
    endfunction

    localparam logic [WIDTH-1:0] RST_GRAY = to_gray(RST_COUNT);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] gray_r;
    logic             wrap_r;
    logic             err_r;
    logic [WIDTH-1:0] next_count_s;
    logic             next_wrap_s;
    logic             next_err_s;
    logic             at_bound_s;
    logic             load_oor_s;
    logic             tc_s;

    // Boundary detect; the widened compare keeps MOD = 2^WIDTH free of overflow
    always_comb begin
        at_bound_s = 1'b0;
        if (up_dn) begin
            at_bound_s = (count_r == MAX_VAL);
        end else begin
            at_bound_s = (count_r == ZERO);
        end
        load_oor_s = ({1'b0, load_val} >= MOD_EXT);
        tc_s       = en & ~load & ~clear & at_bound_s;
    end

    // Next-state selection: clear over load over count over hold
    always_comb begin
        next_count_s = count_r;
        next_err_s   = err_r;
        next_wrap_s  = 1'b0;
        if (clear) begin
            next_count_s = ZERO;
            next_err_s   = 1'b0;
        end else if (load) begin
            if (load_oor_s) begin
                next_count_s = MAX_VAL;
                next_err_s   = 1'b1;
            end else begin
                next_count_s = load_val;
            end
        end else if (en) begin
            next_wrap_s = at_bound_s;
            if (at_bound_s) begin
                next_count_s = up_dn ? ZERO : MAX_VAL;
            end else begin
                next_count_s = up_dn ? (count_r + ONE) : (count_r - ONE);
            end
        end else begin
            next_count_s = count_r;
        end
    end

    // State registers; Gray is derived from the next state so it never lags count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= RST_COUNT;
            gray_r  <= RST_GRAY;
            wrap_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            count_r <= next_count_s;
            gray_r  <= to_gray(next_count_s);
            wrap_r  <= next_wrap_s;
            err_r   <= next_err_s;
        end
    end

    assign count = count_r;
    assign gray  = gray_r;
    assign wrap  = wrap_r;
    assign err   = err_r;
    assign tc    = tc_s;

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised synchronous up/down counter with programmable modulus, parallel load, synchronous clear, registered Gray-code output and terminal-count/wrap flags. It generalises the single toggle-stage counter cell into one multi-bit block. Counter chains and clock-divider blocks use it directly, cascading through `tc`, in place of hand-wired toggle-stage ripple counters.

## Interface
Parameters:
- `WIDTH`, 4: counter width in bits; legal range 2..32.
- `MOD`, 16: count modulus; count range is 0..MOD-1; legal range 2..2^WIDTH.
- `RESET_VAL`, 0: value loaded by reset; must be < MOD.

Ports:
- `clk`  input  1  clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `en`  input  1  count enable.
- `up_dn`  input  1  direction: 1 = up, 0 = down.
- `load`  input  1  synchronous parallel load strobe.
- `load_val`  input  WIDTH  value captured on `load`.
- `clear`  input  1  synchronous clear to 0.
- `count`  output  WIDTH  registered binary count.
- `gray`  output  WIDTH  registered Gray code of `count`.
- `tc`  output  1  combinational terminal count; cascade enable for the next stage.
- `wrap`  output  1  registered one-cycle pulse after a wrap-around.
- `err`  output  1  sticky flag: an out-of-range load was attempted.

## Operation
- Reset is asynchronous and active-high, taken immediately, no clock needed.
  - Reset values: `count` = RESET_VAL, `gray` = RESET_VAL ^ (RESET_VAL >> 1), `wrap` = 0, `err` = 0.
- Per-edge priority, highest first:
  - `clear`: count to 0.
  - `load`: count to `load_val`, or to MOD-1 if `load_val` >= MOD, which also sets `err`.
  - `en`: up counts to count+1, wrapping MOD-1 to 0. Down counts to count-1, wrapping 0 to MOD-1.
  - None of the above: hold.
- `err` is cleared only by `reset` or `clear`; otherwise it stays set once set.
- Arithmetic is modulo MOD, not modulo 2^WIDTH. `count` never holds a value >= MOD.
  - Compare against the wrap boundary before incrementing. No intermediate overflow bit is needed when MOD = 2^WIDTH.
- `gray` is computed from the next-state value and registered on the same edge as `count`. It never lags `count`.
- `tc` = `en` & ~`load` & ~`clear` & (`up_dn` ? `count` == MOD-1 : `count` == 0).
- `wrap` is set for exactly one cycle following an edge at which an enabled count crossed the boundary (MOD-1 to 0 up, or 0 to MOD-1 down).
  - A load or clear never produces `wrap`, even when the loaded value equals the boundary.
- A direction change takes effect on the next counting edge. No extra state is kept.

## Timing
- `count`, `gray`, `wrap`, `err`: registered, one-cycle latency from the sampling edge.
- `tc`: combinational from `count`, `en`, `up_dn`, `load`, `clear`. It is valid in the same cycle as the edge at which the wrap will occur, so it can gate the `en` of the next stage in a synchronous cascade.
- `wrap` rises on the edge after the one where `tc` was high.
- Asserting `reset` mid-count forces reset values asynchronously.
  - Deassertion is synchronised externally.
  - The first count occurs on the first rising edge with `reset` low and `en` high.
- Simultaneous `clear` + `load` + `en`: result is 0, no `wrap`, `err` cleared.
- Simultaneous `load` + `en`: result is the loaded value; the count is ignored for that cycle.

## Test plan
- WIDTH=4, MOD=10; reset, then `en`=1, `up_dn`=1 for 12 cycles -> `count` 0..9,0,1. `tc` high while `count`=9. `wrap` pulses for one cycle when `count` reads 0. `gray` is 0,1,3,2,6,7,5,4,12,13,0,1.
- MOD=10, `count`=0, `up_dn`=0, `en`=1 -> `count` 9,8,7. `tc` high during `count`=0. `wrap` pulses once at `count`=9.
- `load`=1, `load_val`=7, `en`=1 -> `count`=7 next cycle, `err`=0. Then `load_val`=12 -> `count`=9, `err`=1. `err` stays 1 through 5 count cycles and drops only after `clear`.
- `count`=9 (up), `clear`=`load`=`en`=1 on the same edge -> `count`=0, `wrap`=0, `tc`=0 during that cycle.
- Assert `reset` asynchronously mid-cycle at `count`=5 -> `count`=RESET_VAL, `gray` matching, `wrap`=`err`=0 before the next edge. Counting resumes from RESET_VAL after deassertion.
- MOD=16, WIDTH=4; cascade two instances, stage2 `en` = stage1 `tc`; run 300 cycles -> combined value equals cycle count mod 256, with stage2 incrementing exactly once per stage1 wrap.
